pattern_sweep_ctrl: RTL

PATTERN_SWEEP_CTRL -- requirements
Module: pattern_sweep_ctrl

---
 rtl/pattern_sweep_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/pattern_sweep_ctrl.sv
// Exhaustive input-pattern sweep: drives every N_W-bit pattern, samples the DUT response
// after SETTLE cycles and emits one record per pattern. Optional MISR under SWEEP_MISR_EN.
module pattern_sweep_ctrl #(
  parameter int N_W    = 5,
  parameter int SETTLE = 1
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  output logic [N_W-1:0]        n_out,
  input  logic                  dut_out,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [N_W-1:0]        rec_pattern,
  output logic                  rec_bit,
  output logic [(1<<N_W)-1:0]   resp_vec,
  output logic                  busy,
  output logic                  done
`ifdef SWEEP_MISR_EN
  ,
  output logic [15:0]           signature
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_EMIT, ST_DONE} state_t;

  localparam logic [N_W-1:0] LAST      = '1;
  localparam logic [3:0]     SETTLE_LD = 4'(SETTLE);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       go, cap, adv;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    cap      = 1'b0;
    adv      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          go       = 1'b1;
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // count hits zero on this edge: sample the response now
        if (cnt <= 4'd1) begin
          cap      = 1'b1;
          state_nx = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rec_ready) begin
          if (n_out == LAST) state_nx = ST_DONE;
          else begin
            adv      = 1'b1;
            state_nx = ST_SETTLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rec_valid = (state == ST_EMIT);
  assign busy      = (state == ST_SETTLE) || (state == ST_EMIT);
  assign done      = (state == ST_DONE);

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      n_out       <= '0;
      cnt         <= '0;
      rec_pattern <= '0;
      rec_bit     <= 1'b0;
      resp_vec    <= '0;
    end else begin
      if (go) begin
        n_out    <= '0;
        resp_vec <= '0;
        cnt      <= SETTLE_LD;
      end
      if (state == ST_SETTLE) cnt <= cnt - 4'd1;
      if (cap) begin
        rec_bit         <= dut_out;
        rec_pattern     <= n_out;
        resp_vec[n_out] <= dut_out;
      end
      if (adv) begin
        n_out <= n_out + 1'b1;
        cnt   <= SETTLE_LD;
      end
    end
  end

`ifdef SWEEP_MISR_EN
  // x^16+x^12+x^5+1, one captured bit shifted in per record
  logic [15:0] misr_nx;
  assign misr_nx = {signature[14:0], 1'b0} ^ ({16{signature[15] ^ dut_out}} & 16'h1021);

  always_ff @(posedge CK or negedge reset) begin
    if (!reset)   signature <= 16'hFFFF;
    else if (go)  signature <= 16'hFFFF;
    else if (cap) signature <= misr_nx;
  end
`endif

endmodule
